// File: rtl/ram_bus_adapter.sv
// ram_bus_adapter
// Bridges a valid/ready, byte-addressed, byte-strobed request/response bus onto
// a simple block RAM port (write_en/write_address/write_data, read_address/read_data).
// Partial-strobe writes are performed as read-modify-write, because the RAM has
// no byte enables. Out-of-range and misaligned requests are rejected here with
// resp_err and never touch the RAM.
//
// Ports
//   clk, reset                   clock (rising edge), asynchronous active-low reset
//   req_valid/req_ready          request handshake
//   req_write, req_addr          1 = write / 0 = read, byte address
//   req_wdata, req_wstrb         write data and per-byte strobes
//   resp_valid/resp_ready        response handshake
//   resp_rdata, resp_err         read data (0 for writes and errors), error flag
//   ram_write_en/_address/_data  RAM write port
//   ram_read_address             RAM read address
//   ram_read_data                RAM read data, valid the cycle after its address is sampled
module ram_bus_adapter #(
  parameter int unsigned SIZE  = 1024,
  parameter int unsigned WIDTH = 32,
  localparam int unsigned NB = WIDTH / 8,
  localparam int unsigned OB = $clog2(NB),
  localparam int unsigned AW = $clog2(SIZE / NB)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_write,
  input  logic [31:0]      req_addr,
  input  logic [WIDTH-1:0] req_wdata,
  input  logic [NB-1:0]    req_wstrb,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] resp_rdata,
  output logic             resp_err,
  output logic             ram_write_en,
  output logic [AW-1:0]    ram_write_address,
  output logic [WIDTH-1:0] ram_write_data,
  output logic [AW-1:0]    ram_read_address,
  input  logic [WIDTH-1:0] ram_read_data
);

  typedef enum logic [2:0] {
    IDLE,
    RD,
    WR,
    RMW,
    RESP
  } state_t;

  state_t            state, state_next;
  logic [AW-1:0]     addr_q;
  logic [WIDTH-1:0]  wdata_q;
  logic [NB-1:0]     wstrb_q;
  logic [AW-1:0]     idx;
  logic              err;
  logic              accept;
  logic [WIDTH-1:0]  merged;

  assign idx    = req_addr[OB+AW-1:OB];
  // Modulo keeps the alignment check valid even when NB == 1 (no offset bits).
  assign err    = (req_addr >= 32'(SIZE)) || ((req_addr % 32'(NB)) != 32'd0);
  assign accept = req_valid && req_ready;

  assign ram_write_address = addr_q;
  // Read is launched on the accept edge, so the RAM sees the incoming index
  // while idle and the latched index afterwards (RMW merge data).
  assign ram_read_address  = (state == IDLE) ? idx : addr_q;

  always_comb begin
    merged = '0;
    for (int unsigned i = 0; i < NB; i++) begin
      merged[i*8 +: 8] = wstrb_q[i] ? wdata_q[i*8 +: 8] : ram_read_data[i*8 +: 8];
    end
  end

  always_comb begin
    state_next     = state;
    resp_valid     = 1'b0;
    ram_write_en   = 1'b0;
    ram_write_data = wdata_q;
    req_ready      = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (err)                   state_next = RESP;
          else if (!req_write)       state_next = RD;
          else if (req_wstrb == '0)  state_next = RESP;
          else if (req_wstrb == '1)  state_next = WR;
          else                       state_next = RMW;
        end
      end
      RD:  state_next = RESP;
      WR: begin
        ram_write_en = 1'b1;
        state_next   = RESP;
      end
      RMW: begin
        ram_write_en   = 1'b1;
        ram_write_data = merged;
        state_next     = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        addr_q     <= idx;
        wdata_q    <= req_wdata;
        wstrb_q    <= req_wstrb;
        resp_err   <= err;
        resp_rdata <= '0;
      end
      if (state == RD) resp_rdata <= ram_read_data;
    end
  end

endmodule

// File: tb/tb_ram_bus_adapter.sv
module tb_ram_bus_adapter;

  localparam int unsigned SIZE  = 1024;
  localparam int unsigned WIDTH = 32;
  localparam int unsigned NB    = 4;
  localparam int unsigned AW    = 8;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } resp_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             req_valid, req_ready, req_write;
  logic [31:0]      req_addr;
  logic [WIDTH-1:0] req_wdata;
  logic [NB-1:0]    req_wstrb;
  logic             resp_valid, resp_ready, resp_err;
  logic [WIDTH-1:0] resp_rdata;
  logic             ram_write_en;
  logic [AW-1:0]    ram_write_address, ram_read_address;
  logic [WIDTH-1:0] ram_write_data, ram_read_data;

  logic [WIDTH-1:0] mem [0:(1<<AW)-1];
  int               we_count = 0;
  logic [AW-1:0]    last_wa = '0;
  resp_t            sb [$];
  int               passed = 0;
  int               total  = 0;
  int               fails  = 0;

  always #5 clk = ~clk;

  ram_bus_adapter #(.SIZE(SIZE), .WIDTH(WIDTH)) dut (
    .clk(clk), .reset(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .ram_write_en(ram_write_en), .ram_write_address(ram_write_address),
    .ram_write_data(ram_write_data), .ram_read_address(ram_read_address),
    .ram_read_data(ram_read_data)
  );

  // Block RAM model: synchronous write, registered read.
  always @(posedge clk) begin
    if (ram_write_en) begin
      mem[ram_write_address] <= ram_write_data;
      we_count = we_count + 1;
      last_wa  = ram_write_address;
    end
    ram_read_data <= mem[ram_read_address];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one request, check latency, scoreboard response and write-enable activity.
  task automatic do_req(input string tag, input bit wr, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [3:0] st,
                        input logic [31:0] exp_d, input bit exp_e,
                        input int exp_lat, input int exp_we, input int hold);
    resp_t e;
    int    lat;
    int    we0;
    int    i;
    sb.push_back('{rdata: exp_d, err: exp_e});
    @(negedge clk);
    req_valid  = 1'b1;
    req_write  = wr;
    req_addr   = addr;
    req_wdata  = wd;
    req_wstrb  = st;
    resp_ready = (hold == 0);
    i = 0;
    while (!req_ready && i < 20) begin
      @(negedge clk);
      i++;
    end
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    we0 = we_count;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!resp_valid && lat < 20);
    chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    e = sb.pop_front();
    chk({tag, "_rdata"}, resp_rdata, e.rdata);
    chk({tag, "_err"}, 32'(resp_err), 32'(e.err));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk({tag, "_hold_valid"}, 32'(resp_valid), 32'd1);
      chk({tag, "_hold_rdata"}, resp_rdata, e.rdata);
      chk({tag, "_hold_ready"}, 32'(req_ready), 32'd0);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    chk({tag, "_resp_done"}, 32'(resp_valid), 32'd0);
    chk({tag, "_we_count"}, 32'(we_count - we0), 32'(exp_we));
  endtask

  initial begin
    int we0;
    rst_n = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
    req_wdata = '0; req_wstrb = '0; resp_ready = 1'b1;
    #2 rst_n = 1'b0;
    #20;
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_write_en", 32'(ram_write_en), 32'd0);
    @(negedge clk) rst_n = 1'b1;

    // Full write then read-after-write
    do_req("wr_full", 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0, 2, 1, 0);
    chk("wr_full_addr", 32'(last_wa), 32'd4);
    do_req("rd_full", 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0, 2, 0, 0);

    // Last word in range
    do_req("wr_top", 1'b1, 32'h3FC, 32'hCAFEF00D, 4'hF, 32'h0, 1'b0, 2, 1, 0);
    chk("wr_top_addr", 32'(last_wa), 32'd255);
    do_req("rd_top", 1'b0, 32'h3FC, 32'h0, 4'h0, 32'hCAFEF00D, 1'b0, 2, 0, 0);

    // Read-modify-write
    do_req("wr_base", 1'b1, 32'h10, 32'h11223344, 4'hF, 32'h0, 1'b0, 2, 1, 0);
    do_req("rmw", 1'b1, 32'h10, 32'hAABBCCDD, 4'b0101, 32'h0, 1'b0, 2, 1, 0);
    do_req("rd_rmw", 1'b0, 32'h10, 32'h0, 4'h0, 32'h11BB33DD, 1'b0, 2, 0, 0);

    // Errors: out of range, misaligned read and write
    do_req("err_range", 1'b0, 32'h400, 32'h0, 4'h0, 32'h0, 1'b1, 1, 0, 0);
    do_req("err_align", 1'b0, 32'h2, 32'h0, 4'h0, 32'h0, 1'b1, 1, 0, 0);
    do_req("err_wr", 1'b1, 32'h11, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b1, 1, 0, 0);

    // Backpressure on a read
    do_req("bp_rd", 1'b0, 32'h10, 32'h0, 4'h0, 32'h11BB33DD, 1'b0, 2, 0, 5);

    // Zero-strobe write is a no-op
    do_req("wstrb0", 1'b1, 32'h10, 32'h55555555, 4'h0, 32'h0, 1'b0, 1, 0, 0);
    do_req("rd_wstrb0", 1'b0, 32'h10, 32'h0, 4'h0, 32'h11BB33DD, 1'b0, 2, 0, 0);

    // Reset asserted while in RMW: write dropped
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h10;
    req_wdata = 32'hFFFFFFFF; req_wstrb = 4'b0011;
    we0 = we_count;
    @(posedge clk);
    #1 req_valid = 1'b0;
    chk("rst_rmw_we_before", 32'(ram_write_en), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_rmw_we_after", 32'(ram_write_en), 32'd0);
    chk("rst_rmw_valid", 32'(resp_valid), 32'd0);
    @(negedge clk);
    @(negedge clk) rst_n = 1'b1;
    chk("rst_rmw_we_count", 32'(we_count - we0), 32'd0);
    do_req("rd_after_rst", 1'b0, 32'h10, 32'h0, 4'h0, 32'h11BB33DD, 1'b0, 2, 0, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
